// File: rtl/trap_controller.sv
// trap_controller: user-mode trap/return sequencer driving CSR writes and PC redirect (vectored mode under TRAP_VECTORED_EN)
module trap_controller #(
  parameter int TRAP_COUNT_W = 16
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iExcReq,
  input  logic [3:0]              iExcCode,
  input  logic [31:0]             iExcPC,
  input  logic [31:0]             iExcTval,
  input  logic [2:0]              iIrqPending,
  input  logic                    iInstrValid,
  input  logic [31:0]             iRetirePC,
  input  logic                    iUret,
  input  logic [31:0]             iUSTATUS,
  input  logic [31:0]             iUTVEC,
  input  logic [31:0]             iUEPC,
  input  logic [31:0]             iUIE,
  output logic                    oRegWriteSimu,
  output logic [31:0]             oWriteDataUEPC,
  output logic [31:0]             oWriteDataUCAUSE,
  output logic [31:0]             oWriteDataUTVAL,
  output logic                    oCsrWe,
  output logic [11:0]             oCsrAddr,
  output logic [31:0]             oCsrData,
  output logic                    oPCRedirect,
  output logic [31:0]             oPCTarget,
  output logic                    oFlush,
  output logic                    oBusy,
  output logic [TRAP_COUNT_W-1:0] oTrapCount
);
  typedef enum logic [2:0] {IDLE, SAVE, STAT, REDIR, RSTAT, RREDIR} state_t;
  state_t state;
  logic [31:0] epc_q, cause_q, tval_q, base, trap_target;
  logic [2:0] irq_en;
  logic [3:0] irq_code;
  logic idle, exc_acc, irq_acc, ret_acc;
  logic unused_bits;
  assign unused_bits = ^{iUIE[31:9], iUIE[7:5], iUIE[3:1], iUTVEC[1:0], iUEPC[1:0]};
  // accept arbitration: exception > enabled interrupt at an instruction boundary > uret
  always_comb begin
    idle = state == IDLE;
    irq_en = iIrqPending & {iUIE[8], iUIE[4], iUIE[0]};
    exc_acc = idle & iExcReq;
    irq_acc = idle & ~iExcReq & iInstrValid & iUSTATUS[0] & (|irq_en);
    ret_acc = idle & ~iExcReq & ~irq_acc & iUret;
    irq_code = irq_en[2] ? 4'd8 : irq_en[0] ? 4'd0 : 4'd4;
    base = {iUTVEC[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    trap_target = (cause_q[31] && iUTVEC[1:0] == 2'b01) ? base + {26'b0, cause_q[3:0], 2'b00} : base;
`else
    trap_target = base;
`endif
  end
  assign oBusy = ~idle | exc_acc | irq_acc | ret_acc;
  assign oRegWriteSimu = state == SAVE;
  assign oWriteDataUEPC = epc_q;
  assign oWriteDataUCAUSE = cause_q;
  assign oWriteDataUTVAL = tval_q;
  assign oCsrWe = (state == STAT) | (state == RSTAT);
  assign oCsrAddr = 12'h000;
  assign oCsrData = state == STAT  ? {iUSTATUS[31:5], iUSTATUS[0], iUSTATUS[3:1], 1'b0} :
                    state == RSTAT ? {iUSTATUS[31:5], 1'b1, iUSTATUS[3:1], iUSTATUS[4]} : 32'h0;
  assign oPCRedirect = (state == REDIR) | (state == RREDIR);
  assign oFlush = oPCRedirect;
  assign oPCTarget = state == REDIR  ? trap_target :
                     state == RREDIR ? {iUEPC[31:2], 2'b00} : 32'h0;
  // sequence state, latched trap record and saturating taken-trap counter
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
      epc_q <= '0;
      cause_q <= '0;
      tval_q <= '0;
      oTrapCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (exc_acc) begin
            state <= SAVE;
            epc_q <= iExcPC;
            cause_q <= {28'b0, iExcCode};
            tval_q <= iExcTval;
          end else if (irq_acc) begin
            state <= SAVE;
            epc_q <= iRetirePC;
            cause_q <= {1'b1, 27'b0, irq_code};
            tval_q <= '0;
          end else if (ret_acc) begin
            state <= RSTAT;
          end
        end
        SAVE: state <= STAT;
        STAT: state <= REDIR;
        REDIR: begin
          state <= IDLE;
          oTrapCount <= oTrapCount + {{(TRAP_COUNT_W-1){1'b0}}, ~&oTrapCount};
        end
        RSTAT: state <= RREDIR;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: table-driven directed check of trap_controller sequences
module tb_trap_controller;
  localparam int CW = 3;
`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] VT = 32'h810;
`else
  localparam logic [31:0] VT = 32'h800;
`endif
  logic iCLK, iRST, iExcReq, iInstrValid, iUret;
  logic [3:0] iExcCode;
  logic [31:0] iExcPC, iExcTval, iRetirePC, iUSTATUS, iUTVEC, iUEPC, iUIE;
  logic [2:0] iIrqPending;
  logic oRegWriteSimu, oCsrWe, oPCRedirect, oFlush, oBusy;
  logic [31:0] oWriteDataUEPC, oWriteDataUCAUSE, oWriteDataUTVAL, oCsrData, oPCTarget;
  logic [11:0] oCsrAddr;
  logic [CW-1:0] oTrapCount;
  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  trap_controller #(.TRAP_COUNT_W(CW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iExcReq(iExcReq), .iExcCode(iExcCode), .iExcPC(iExcPC),
    .iExcTval(iExcTval), .iIrqPending(iIrqPending), .iInstrValid(iInstrValid),
    .iRetirePC(iRetirePC), .iUret(iUret), .iUSTATUS(iUSTATUS), .iUTVEC(iUTVEC),
    .iUEPC(iUEPC), .iUIE(iUIE), .oRegWriteSimu(oRegWriteSimu),
    .oWriteDataUEPC(oWriteDataUEPC), .oWriteDataUCAUSE(oWriteDataUCAUSE),
    .oWriteDataUTVAL(oWriteDataUTVAL), .oCsrWe(oCsrWe), .oCsrAddr(oCsrAddr),
    .oCsrData(oCsrData), .oPCRedirect(oPCRedirect), .oPCTarget(oPCTarget),
    .oFlush(oFlush), .oBusy(oBusy), .oTrapCount(oTrapCount)
  );

  initial iCLK = 0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    int          kind;
    logic        exc;
    logic [3:0]  code;
    logic [31:0] epc_in, tval_in;
    logic [2:0]  irq;
    logic        valid;
    logic [31:0] rpc;
    logic        uret;
    logic [31:0] ustatus, utvec, uie, uepc;
    logic [31:0] e_epc, e_cause, e_tval, e_csr, e_tgt;
  } vec_t;
  vec_t vec[11];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  task automatic run(input vec_t v);
    iExcReq = v.exc; iExcCode = v.code; iExcPC = v.epc_in; iExcTval = v.tval_in;
    iIrqPending = v.irq; iInstrValid = v.valid; iRetirePC = v.rpc; iUret = v.uret;
    iUSTATUS = v.ustatus; iUTVEC = v.utvec; iUIE = v.uie; iUEPC = v.uepc;
    #1;
    chk("accept_busy", 32'(oBusy), 32'(v.kind != 0));
    @(posedge iCLK); #1;
    iExcReq = 0; iIrqPending = 0; iInstrValid = 0; iUret = 0;
    if (v.kind == 1) begin
      chk("save_strobe", 32'(oRegWriteSimu), 1);
      chk("save_uepc", oWriteDataUEPC, v.e_epc);
      chk("save_ucause", oWriteDataUCAUSE, v.e_cause);
      chk("save_utval", oWriteDataUTVAL, v.e_tval);
      chk("save_busy", 32'(oBusy), 1);
      @(posedge iCLK); #1;
      chk("stat_we", 32'(oCsrWe), 1);
      chk("stat_addr", 32'(oCsrAddr), 0);
      chk("stat_data", oCsrData, v.e_csr);
      chk("stat_busy", 32'(oBusy), 1);
      @(posedge iCLK); #1;
      chk("redir_pulse", 32'({oPCRedirect, oFlush}), 3);
      chk("redir_target", oPCTarget, v.e_tgt);
      chk("redir_busy", 32'(oBusy), 1);
      exp_cnt = exp_cnt == (1 << CW) - 1 ? exp_cnt : exp_cnt + 1;
      @(posedge iCLK); #1;
      chk("trap_done_busy", 32'(oBusy), 0);
      chk("trap_done_redir", 32'(oPCRedirect), 0);
      chk("trap_count", 32'(oTrapCount), 32'(exp_cnt));
    end else if (v.kind == 2) begin
      chk("rstat_we", 32'(oCsrWe), 1);
      chk("rstat_data", oCsrData, v.e_csr);
      chk("rstat_simu", 32'(oRegWriteSimu), 0);
      @(posedge iCLK); #1;
      chk("rredir_pulse", 32'({oPCRedirect, oFlush}), 3);
      chk("rredir_target", oPCTarget, v.e_tgt);
      @(posedge iCLK); #1;
      chk("ret_done_busy", 32'(oBusy), 0);
      chk("ret_count", 32'(oTrapCount), 32'(exp_cnt));
    end else begin
      chk("none_busy", 32'(oBusy), 0);
      chk("none_strobes", 32'({oRegWriteSimu, oCsrWe, oPCRedirect}), 0);
    end
  endtask

  initial begin
    vec[0]  = '{1, 1, 4'h2, 32'h400, 32'hDEAD, 3'b000, 0, 32'h0, 0, 32'h1, 32'h800, 32'h0, 32'h0, 32'h400, 32'h2, 32'hDEAD, 32'h10, 32'h800};
    vec[1]  = '{1, 0, 4'h0, 32'h0, 32'h0, 3'b110, 1, 32'h1234, 0, 32'h1, 32'h800, 32'h110, 32'h0, 32'h1234, 32'h80000008, 32'h0, 32'h10, 32'h800};
    vec[2]  = '{0, 0, 4'h0, 32'h0, 32'h0, 3'b110, 1, 32'h1234, 0, 32'h0, 32'h800, 32'h110, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vec[3]  = '{0, 0, 4'h0, 32'h0, 32'h0, 3'b110, 0, 32'h1234, 0, 32'h1, 32'h800, 32'h110, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vec[4]  = '{1, 1, 4'h5, 32'h100, 32'h44, 3'b000, 0, 32'h0, 1, 32'h11, 32'h803, 32'h0, 32'h0, 32'h100, 32'h5, 32'h44, 32'h10, 32'h800};
    vec[5]  = '{2, 0, 4'h0, 32'h0, 32'h0, 3'b000, 0, 32'h0, 1, 32'h10, 32'h800, 32'h0, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h11, 32'h1234};
    vec[6]  = '{1, 0, 4'h0, 32'h0, 32'h0, 3'b010, 1, 32'h2000, 0, 32'h1, 32'h801, 32'h010, 32'h0, 32'h2000, 32'h80000004, 32'h0, 32'h10, VT};
    vec[7]  = '{1, 0, 4'h0, 32'h0, 32'h0, 3'b011, 1, 32'h3000, 0, 32'h1, 32'h801, 32'h011, 32'h0, 32'h3000, 32'h80000000, 32'h0, 32'h10, 32'h800};
    vec[8]  = '{0, 0, 4'h0, 32'h0, 32'h0, 3'b100, 1, 32'h3000, 0, 32'h1, 32'h800, 32'h011, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vec[9]  = '{2, 0, 4'h0, 32'h0, 32'h0, 3'b000, 0, 32'h0, 1, 32'hFFFFFFE0, 32'h800, 32'h0, 32'h1237, 32'h0, 32'h0, 32'h0, 32'hFFFFFFF0, 32'h1234};
    vec[10] = '{1, 1, 4'hF, 32'h500, 32'h77, 3'b000, 0, 32'h0, 0, 32'hFFFFFFFF, 32'h2001, 32'h0, 32'h0, 32'h500, 32'hF, 32'h77, 32'hFFFFFFFE, 32'h2000};
    iRST = 1; iExcReq = 0; iExcCode = 0; iExcPC = 0; iExcTval = 0; iIrqPending = 0;
    iInstrValid = 0; iRetirePC = 0; iUret = 0; iUSTATUS = 0; iUTVEC = 0; iUEPC = 0; iUIE = 0;
    repeat (2) @(posedge iCLK);
    #1;
    chk("reset_busy", 32'(oBusy), 0);
    chk("reset_strobes", 32'({oRegWriteSimu, oCsrWe, oPCRedirect, oFlush}), 0);
    chk("reset_data", oWriteDataUEPC | oWriteDataUCAUSE | oWriteDataUTVAL | oCsrData | oPCTarget, 0);
    chk("reset_count", 32'(oTrapCount), 0);
    iRST = 0;
    for (int i = 0; i < 11; i++) run(vec[i]);
    for (int i = 0; i < 3; i++) run(vec[0]);
    iExcReq = 1; iExcCode = 4'h2; iExcPC = 32'h400; iExcTval = 32'hDEAD; iUSTATUS = 32'h1; iUTVEC = 32'h800;
    @(posedge iCLK); #1;
    iExcReq = 0;
    @(posedge iCLK); #1;
    chk("abort_in_stat", 32'(oCsrWe), 1);
    iRST = 1;
    #1;
    chk("abort_strobes", 32'({oRegWriteSimu, oCsrWe, oPCRedirect, oFlush, oBusy}), 0);
    chk("abort_data", oWriteDataUEPC | oWriteDataUCAUSE | oWriteDataUTVAL | oCsrData | oPCTarget, 0);
    chk("abort_count", 32'(oTrapCount), 0);
    @(posedge iCLK); #1;
    iRST = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge iCLK); #1;
      chk("abort_no_redirect", 32'({oPCRedirect, oBusy, oCsrWe}), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- User-mode (N-extension) trap sequencer. It drives the trap side of the CSR register file: the simultaneous uepc/ucause/utval write strobe, the ustatus update through the normal CSR write port, and the PC redirect.
- Accepts synchronous exceptions, level-sensitive user interrupts and uret from the core.
- Stalls the core with oBusy while a trap or return sequence is in flight.

Parameters:
- TRAP_COUNT_W, 16, width of the saturating taken-trap counter oTrapCount.

Ports:
- iCLK  in  1  clock; all state updates on the rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iExcReq  in  1  exception request from the execute stage.
- iExcCode  in  4  exception cause code.
- iExcPC  in  32  PC of the faulting instruction.
- iExcTval  in  32  trap value (bad address or instruction).
- iIrqPending  in  3  pending interrupts: [0] software, [1] timer, [2] external.
- iInstrValid  in  1  an instruction boundary is available; interrupts may only be injected here.
- iRetirePC  in  32  PC of the next instruction; becomes uepc on an interrupt.
- iUret  in  1  uret is executing.
- iUSTATUS, iUTVEC, iUEPC, iUIE  in  32 each  live CSR values (UIE = ustatus bit 0, UPIE = ustatus bit 4; uie bits 0/4/8).
- oRegWriteSimu  out  1  simultaneous uepc/ucause/utval write strobe.
- oWriteDataUEPC, oWriteDataUCAUSE, oWriteDataUTVAL  out  32 each  data for that write.
- oCsrWe  out  1  normal CSR write enable.
- oCsrAddr  out  12  normal CSR write address; always 12'h000 (ustatus).
- oCsrData  out  32  normal CSR write data.
- oPCRedirect  out  1  one-cycle pulse that loads oPCTarget into the PC.
- oPCTarget  out  32  redirect target.
- oFlush  out  1  flush the younger pipeline stages; equal to oPCRedirect.
- oBusy  out  1  stall request to the core.
- oTrapCount  out  TRAP_COUNT_W  saturating count of taken traps (exceptions plus interrupts).

Behaviour:
- Reset: state IDLE; every output 0; latched epc/cause/tval 0; oTrapCount 0. Reset asserted mid-sequence aborts immediately with no further writes or redirect.

- States and sequences (one cycle per state after the accept cycle):
  - Trap: IDLE -> SAVE -> STAT -> REDIR -> IDLE.
  - Return: IDLE -> RSTAT -> RREDIR -> IDLE.

- Accept (in IDLE only), priority highest first:
  1. Exception: iExcReq=1.
     - ucause = {28'b0, iExcCode}; epc = iExcPC; tval = iExcTval.
  2. Interrupt: iInstrValid=1 and iUSTATUS[0]=1 and (pending & enabled) != 0.
     - Enabled means iUIE bit 8 for external, bit 0 for software, bit 4 for timer.
     - Priority among interrupts: external (code 8) > software (code 0) > timer (code 4).
     - ucause = {1'b1, 27'b0, code}; epc = iRetirePC; tval = 0.
  3. Return: iUret=1.

- All requests arriving while not in IDLE are ignored; the core holds them stalled.

- Accept cycle:
  - Latch epc, cause and tval.
  - oBusy is asserted combinationally in this same cycle.

- SAVE: oRegWriteSimu=1; the data outputs carry the latched values.

- STAT: oCsrWe=1; oCsrData = {iUSTATUS[31:5], iUSTATUS[0], iUSTATUS[3:1], 1'b0}, i.e. UPIE<=UIE, UIE<=0.

- RSTAT: oCsrWe=1; oCsrData = {iUSTATUS[31:5], 1'b1, iUSTATUS[3:1], iUSTATUS[4]}, i.e. UIE<=UPIE, UPIE<=1.

- REDIR:
  - oPCRedirect=1, oFlush=1.
  - oPCTarget = {iUTVEC[31:2], 2'b00}, sampled in this cycle so a same-sequence utvec write is honoured.
  - oTrapCount increments, saturating at all-ones.

- RREDIR:
  - oPCRedirect=1, oFlush=1.
  - oPCTarget = {iUEPC[31:2], 2'b00}.
  - oTrapCount unchanged.

- oBusy = (state != IDLE) | accept. It is low in the cycle after REDIR or RREDIR.

- Data outputs are held at their last latched values outside SAVE; strobes are 0 outside their states.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: when iUTVEC[1:0] == 2'b01 and the cause is an interrupt, the REDIR target = {iUTVEC[31:2], 2'b00} + 4*code. Exceptions still use the base. Mode values 2 and 3 are treated as direct.
- Undefined: iUTVEC[1:0] is ignored and every trap uses the base.

Test Plan:
- Exception with iExcCode=2, iExcPC=0x400, iExcTval=0xDEAD, utvec=0x800: oBusy high for 4 cycles; SAVE writes uepc 0x400, ucause 2, utval 0xDEAD; STAT writes ustatus 0x10 from ustatus 0x01; REDIR pulses target 0x800; oTrapCount=1.
- ustatus=0x1, uie=0x110, iIrqPending=3'b110, iInstrValid=1, iRetirePC=0x1234: external wins; ucause 0x80000008, uepc 0x1234, utval 0.
- Interrupt pending with ustatus[0]=0, or with iInstrValid=0: no accept; oBusy stays 0.
- iExcReq and iUret asserted together: trap sequence runs. Then uret alone with ustatus=0x10, uepc=0x1234: RSTAT writes 0x11; RREDIR target 0x1234; 3-cycle busy.
- Assert iRST during STAT: all outputs 0 next cycle; no redirect; state IDLE.
- With TRAP_VECTORED_EN, utvec=0x801, timer interrupt: target 0x810. Without the macro: target 0x800.
